// File: rtl/pc_hazard_ctrl.sv
// PC / stage-register sequencer for the 5-stage core: boot hold,
// load-use bubbles, dmem freeze, branch redirect (with imem-busy pend).
//
// Ports:
//   clk, reset (async, active-low)
//   id_rs1/id_rs2/id_use_rs1/id_use_rs2 : ID source operands
//   ex_rd/ex_mem_read                   : EX destination / load flag
//   ex_branch_taken/ex_branch_target    : resolved redirect from EX
//   mem_req/dmem_ready                  : data-memory handshake
//   imem_ready                          : instruction fetch valid
//   pc_plus4                            : sequential PC
//   pc_next, stall_*, flush_*           : PC / pipeline register control
//   timeout_err                         : sticky dmem-timeout flag
module pc_hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int BOOT_CYCLES = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            mem_req,
  input  logic            dmem_ready,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next,
  output logic            stall_PC,
  output logic            stall_IFID,
  output logic            flush_IFID,
  output logic            stall_IDEX,
  output logic            flush_IDEX,
  output logic            stall_EXMEM,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int BW =
    (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [BW-1:0] BOOT_INIT =
    BW'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);
  localparam state_t RST_ST =
    (BOOT_CYCLES == 0) ? RUN : BOOT;

  state_t          state;
  state_t          state_nx;
  logic [BW-1:0]   boot_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [XLEN-1:0] redir_q;
  logic            freeze;
  logic            load_use;
  logic            redir_park;

  assign freeze = (state != BOOT)
                & mem_req & ~dmem_ready;

  // x0 is hard-wired zero, so a load to it never creates a hazard.
  assign load_use = ex_mem_read
                  & (ex_rd != 5'd0)
                  & ((id_use_rs1 & (id_rs1 == ex_rd))
                   | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Taken branch while fetch is busy: remember target, finish later.
  assign redir_park = (state == RUN) & ~freeze
                    & ex_branch_taken & ~imem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RST_ST;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:
        if (boot_cnt == '0) state_nx = RUN;
      RUN:
        if (redir_park) state_nx = PEND;
      PEND:
        if (imem_ready && !freeze) state_nx = RUN;
      default:
        state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boot_cnt    <= BOOT_INIT;
      wait_cnt    <= '0;
      redir_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == BOOT && boot_cnt != '0)
        boot_cnt <= boot_cnt - 1'b1;
      if (redir_park)
        redir_q <= ex_branch_target;
      if (freeze) begin
        if (wait_cnt != MAX_W)
          wait_cnt <= wait_cnt + 1'b1;
        // Edge closing the MAX_WAIT-th back-to-back freeze cycle.
        if (wait_cnt >= MAX_W - 1'b1)
          timeout_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    pc_next     = pc_plus4;
    stall_PC    = 1'b0;
    stall_IFID  = 1'b0;
    flush_IFID  = 1'b0;
    stall_IDEX  = 1'b0;
    flush_IDEX  = 1'b0;
    stall_EXMEM = 1'b0;
    unique case (state)
      BOOT: begin
        stall_PC   = 1'b1;
        flush_IFID = 1'b1;
        flush_IDEX = 1'b1;
      end
      RUN: begin
        if (freeze) begin
          // EX is held, so any branch there is re-presented later.
          stall_PC    = 1'b1;
          stall_IFID  = 1'b1;
          stall_IDEX  = 1'b1;
          stall_EXMEM = 1'b1;
        end else if (ex_branch_taken) begin
          flush_IFID = 1'b1;
          flush_IDEX = 1'b1;
          if (imem_ready)
            pc_next = ex_branch_target;
          else
            stall_PC = 1'b1;
        end else if (load_use) begin
          stall_PC   = 1'b1;
          stall_IFID = 1'b1;
          flush_IDEX = 1'b1;
        end else if (!imem_ready) begin
          stall_PC   = 1'b1;
          flush_IFID = 1'b1;
        end
      end
      PEND: begin
        pc_next = redir_q;
        if (freeze) begin
          stall_PC    = 1'b1;
          stall_IFID  = 1'b1;
          stall_IDEX  = 1'b1;
          stall_EXMEM = 1'b1;
        end else begin
          flush_IFID = 1'b1;
          stall_PC   = ~imem_ready;
        end
      end
      default: begin
        stall_PC   = 1'b1;
        flush_IFID = 1'b1;
        flush_IDEX = 1'b1;
      end
    endcase
  end

endmodule
